alu_share_arbiter: RTL and testbench

//  Shares the single combinational ALU between two requesters (e.g. execute stage and branch unit).

---
 rtl/alu_share_arbiter_if.sv | 39 +++
 rtl/alu_share_arbiter.sv | 93 +++++++++
 tb/tb_alu_share_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - requester, ALU and response signal bundle for alu_share_arbiter
interface alu_share_arbiter_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [CTRL_W-1:0] req_op0;
   logic [WIDTH-1:0]  req_a0;
   logic [WIDTH-1:0]  req_b0;
   logic [CTRL_W-1:0] req_op1;
   logic [WIDTH-1:0]  req_a1;
   logic [WIDTH-1:0]  req_b1;
   logic [WIDTH-1:0]  alu_a;
   logic [WIDTH-1:0]  alu_b;
   logic [CTRL_W-1:0] alu_ctrl;
   logic [WIDTH-1:0]  alu_c;
   logic              alu_zero;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_zero;
   logic              rsp_err;
   logic              busy;

   modport master (
      output req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
      output alu_c, alu_zero, rsp_ready,
      input  req_ready, alu_a, alu_b, alu_ctrl,
      input  rsp_valid, rsp_data, rsp_zero, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_op0, req_a0, req_b0, req_op1, req_a1, req_b1,
      input  alu_c, alu_zero, rsp_ready,
      output req_ready, alu_a, alu_b, alu_ctrl,
      output rsp_valid, rsp_data, rsp_zero, rsp_err, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters
// Grant in IDLE, let the ALU settle in EXEC, hold the captured result in RESP until the owner accepts.
module alu_share_arbiter #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4,
   parameter bit RR_EN  = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [CTRL_W-1:0] OP_BEQ  = CTRL_W'(4'b1001);
   localparam logic [CTRL_W-1:0] OP_BNE  = CTRL_W'(4'b1010);
   localparam logic [CTRL_W-1:0] OP_LAST = CTRL_W'(4'b1010);
   localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);

   state_t            state, state_nxt;
   logic              grant, grant_vld;
   logic              owner, last_grant;
   logic [1:0]        req_ready;
   logic [WIDTH-1:0]  alu_a_q, alu_b_q, rsp_data_q;
   logic [CTRL_W-1:0] alu_ctrl_q;
   logic              rsp_zero_q, rsp_err_q;
   logic              op_ok, op_cmp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      grant_vld = 1'b0;
      req_ready = 2'b00;
      case (state)
         IDLE: begin
            if (|bus.req_valid) begin
               grant_vld = 1'b1;
               if (bus.req_valid == 2'b11) grant = RR_EN ? ~last_grant : 1'b0;
               else                        grant = bus.req_valid[1];
               req_ready = grant ? 2'b10 : 2'b01;
               state_nxt = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (bus.rsp_ready[owner]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The ALU leaves C stale for unknown codes and only drives zero for compares.
   assign op_ok  = (alu_ctrl_q <= OP_LAST) || (alu_ctrl_q == OP_NOR);
   assign op_cmp = (alu_ctrl_q == OP_BEQ) || (alu_ctrl_q == OP_BNE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_ctrl_q <= '0;
         rsp_data_q <= '0;
         rsp_zero_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if (state == IDLE && grant_vld) begin
            alu_ctrl_q <= grant ? bus.req_op1 : bus.req_op0;
            alu_a_q    <= grant ? bus.req_a1  : bus.req_a0;
            alu_b_q    <= grant ? bus.req_b1  : bus.req_b0;
            owner      <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_data_q <= op_ok ? bus.alu_c : '0;
            rsp_zero_q <= op_ok && op_cmp && bus.alu_zero;
            rsp_err_q  <= !op_ok;
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_zero  = rsp_zero_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and random checks of alu_share_arbiter against a transaction model
module tb_alu_share_arbiter;
   localparam int W  = 32;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.WIDTH(W), .CTRL_W(CW)) if_rr ();
   alu_share_arbiter_if #(.WIDTH(W), .CTRL_W(CW)) if_fp ();

   alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW), .RR_EN(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr));
   alu_share_arbiter #(.WIDTH(W), .CTRL_W(CW), .RR_EN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(if_fp));

   logic          sel;
   logic [1:0]    v, rdy;
   logic [CW-1:0] op [2];
   logic [W-1:0]  a [2];
   logic [W-1:0]  b [2];
   logic          stale_zero;
   int            errors = 0;
   int            checks = 0;
   logic          model_last;

   // Reference ALU: 0 and, 1 or, 2 add, 3 xor, 4 sll, 5 srl, 6 sub, 7 slt, 8 sra, 9 eq, 10 ne, 12 nor.
   function automatic logic [W-1:0] alu_fn(input logic [CW-1:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
      case (c)
         4'd0:    return x & y;
         4'd1:    return x | y;
         4'd2:    return x + y;
         4'd3:    return x ^ y;
         4'd4:    return y << x[4:0];
         4'd5:    return y >> x[4:0];
         4'd6:    return x - y;
         4'd7:    return {31'd0, $signed(x) < $signed(y)};
         4'd8:    return $signed(y) >>> x[4:0];
         4'd9:    return {31'd0, x == y};
         4'd10:   return {31'd0, x != y};
         4'd12:   return ~(x | y);
         default: return 32'hdead_beef;
      endcase
   endfunction

   assign if_rr.req_valid = sel ? 2'b00 : v;
   assign if_fp.req_valid = sel ? v : 2'b00;
   assign if_rr.rsp_ready = sel ? 2'b00 : rdy;
   assign if_fp.rsp_ready = sel ? rdy : 2'b00;
   assign if_rr.req_op0 = op[0];
   assign if_rr.req_a0  = a[0];
   assign if_rr.req_b0  = b[0];
   assign if_rr.req_op1 = op[1];
   assign if_rr.req_a1  = a[1];
   assign if_rr.req_b1  = b[1];
   assign if_fp.req_op0 = op[0];
   assign if_fp.req_a0  = a[0];
   assign if_fp.req_b0  = b[0];
   assign if_fp.req_op1 = op[1];
   assign if_fp.req_a1  = a[1];
   assign if_fp.req_b1  = b[1];
   assign if_rr.alu_c    = alu_fn(if_rr.alu_ctrl, if_rr.alu_a, if_rr.alu_b);
   assign if_fp.alu_c    = alu_fn(if_fp.alu_ctrl, if_fp.alu_a, if_fp.alu_b);
   assign if_rr.alu_zero = (if_rr.alu_ctrl == 4'd9 || if_rr.alu_ctrl == 4'd10) ? if_rr.alu_c[0] : stale_zero;
   assign if_fp.alu_zero = (if_fp.alu_ctrl == 4'd9 || if_fp.alu_ctrl == 4'd10) ? if_fp.alu_c[0] : stale_zero;

   logic [1:0]    o_req_ready, o_rsp_valid;
   logic [W-1:0]  o_alu_a, o_alu_b, o_rsp_data;
   logic [CW-1:0] o_alu_ctrl;
   logic          o_rsp_zero, o_rsp_err, o_busy;
   assign o_req_ready = sel ? if_fp.req_ready : if_rr.req_ready;
   assign o_rsp_valid = sel ? if_fp.rsp_valid : if_rr.rsp_valid;
   assign o_alu_a     = sel ? if_fp.alu_a     : if_rr.alu_a;
   assign o_alu_b     = sel ? if_fp.alu_b     : if_rr.alu_b;
   assign o_alu_ctrl  = sel ? if_fp.alu_ctrl  : if_rr.alu_ctrl;
   assign o_rsp_data  = sel ? if_fp.rsp_data  : if_rr.rsp_data;
   assign o_rsp_zero  = sel ? if_fp.rsp_zero  : if_rr.rsp_zero;
   assign o_rsp_err   = sel ? if_fp.rsp_err   : if_rr.rsp_err;
   assign o_busy      = sel ? if_fp.busy      : if_rr.busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req_ready"}, 64'(o_req_ready), 64'd0);
      chk({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'd0);
      chk({tag, "_alu_a"},     64'(o_alu_a),     64'd0);
      chk({tag, "_alu_b"},     64'(o_alu_b),     64'd0);
      chk({tag, "_alu_ctrl"},  64'(o_alu_ctrl),  64'd0);
      chk({tag, "_rsp_data"},  64'(o_rsp_data),  64'd0);
      chk({tag, "_rsp_zero"},  64'(o_rsp_zero),  64'd0);
      chk({tag, "_rsp_err"},   64'(o_rsp_err),   64'd0);
      chk({tag, "_busy"},      64'(o_busy),      64'd0);
   endtask

   task automatic set_req(input int i, input logic [CW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      op[i] = o;
      a[i]  = x;
      b[i]  = y;
      v[i]  = 1'b1;
   endtask

   task automatic rand_req(input int i);
      logic [W-1:0] x;
      x = $urandom;
      set_req(i, CW'($urandom_range(0, 15)), x, ($urandom_range(0, 3) == 0) ? x : W'($urandom));
   endtask

   // One full transaction; starts just after a clock edge with requests driven, ends just after the handshake edge.
   task automatic txn(input int hold);
      logic          g;
      logic [1:0]    g_hot, o_hot;
      logic [CW-1:0] eop;
      logic [W-1:0]  ea, eb, edata;
      logic          ezero, eerr;
      @(negedge clk);
      chk("idle_busy", 64'(o_busy), 64'd0);
      chk("idle_rsp_valid", 64'(o_rsp_valid), 64'd0);
      if (v == 2'b11) g = (sel == 1'b0) ? ~model_last : 1'b0;
      else            g = v[1];
      g_hot = g ? 2'b10 : 2'b01;
      o_hot = g ? 2'b01 : 2'b10;
      chk("grant", 64'(o_req_ready), 64'(g_hot));
      eop = op[g];
      ea  = a[g];
      eb  = b[g];
      eerr  = !(eop inside {[4'd0:4'd10], 4'd12});
      edata = eerr ? '0 : alu_fn(eop, ea, eb);
      ezero = (eop == 4'd9) ? (ea == eb) : (eop == 4'd10) ? (ea != eb) : 1'b0;
      if (sel == 1'b0) model_last = g;
      @(posedge clk);
      #1 v[g] = 1'b0;
      @(negedge clk);
      chk("exec_busy", 64'(o_busy), 64'd1);
      chk("exec_req_ready", 64'(o_req_ready), 64'd0);
      chk("exec_rsp_valid", 64'(o_rsp_valid), 64'd0);
      chk("alu_a", 64'(o_alu_a), 64'(ea));
      chk("alu_b", 64'(o_alu_b), 64'(eb));
      chk("alu_ctrl", 64'(o_alu_ctrl), 64'(eop));
      @(posedge clk);
      #1 rdy = o_hot;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 64'(o_rsp_valid), 64'(g_hot));
         chk("hold_rsp_data", 64'(o_rsp_data), 64'(edata));
         chk("hold_busy", 64'(o_busy), 64'd1);
         chk("hold_req_ready", 64'(o_req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      rdy = g_hot;
      @(negedge clk);
      chk("rsp_valid", 64'(o_rsp_valid), 64'(g_hot));
      chk("rsp_data", 64'(o_rsp_data), 64'(edata));
      chk("rsp_zero", 64'(o_rsp_zero), 64'(ezero));
      chk("rsp_err", 64'(o_rsp_err), 64'(eerr));
      @(posedge clk);
      #1 rdy = 2'b00;
   endtask

   initial begin
      sel = 1'b0;
      v = 2'b00;
      rdy = 2'b00;
      stale_zero = 1'b0;
      model_last = 1'b1;
      for (int i = 0; i < 2; i++) begin
         op[i] = '0;
         a[i]  = '0;
         b[i]  = '0;
      end
      @(negedge clk);
      chk_reset("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // T1: single requester add, 7 + -3
      set_req(0, 4'b0010, 32'd7, -32'sd3);
      txn(0);

      // T2: both requesters continuously valid, round-robin
      set_req(0, 4'b0110, 32'd100, 32'd1);
      set_req(1, 4'b0110, 32'd50, 32'd60);
      for (int k = 0; k < 4; k++) begin
         txn(1);
         if (!v[0]) set_req(0, 4'b0110, W'($urandom), W'($urandom));
         if (!v[1]) set_req(1, 4'b0110, W'($urandom), W'($urandom));
      end
      v = 2'b00;

      // T4: compare flag, then a non-compare op with a stale zero from the ALU
      set_req(1, 4'b1001, 32'd5, 32'd5);
      txn(0);
      stale_zero = 1'b1;
      set_req(1, 4'b0010, 32'd5, 32'd5);
      txn(0);

      // T5: unsupported op with a long-stalled response
      set_req(0, 4'b1111, 32'd9, 32'd9);
      txn(10);

      // T3: fixed priority starves req1 until req0 drops
      sel = 1'b1;
      set_req(0, 4'b0000, 32'hff00, 32'h0ff0);
      set_req(1, 4'b0001, 32'h1234, 32'h4321);
      for (int k = 0; k < 4; k++) begin
         txn(0);
         set_req(0, 4'b0011, W'($urandom), W'($urandom));
      end
      v[0] = 1'b0;
      txn(0);

      // Random traffic on both variants
      for (int k = 0; k < 80; k++) begin
         sel = (k >= 40);
         for (int i = 0; i < 2; i++)
            if (!v[i] && $urandom_range(0, 1) == 1) rand_req(i);
         if (v == 2'b00) rand_req($urandom_range(0, 1));
         stale_zero = 1'($urandom);
         txn($urandom_range(0, 2));
      end
      v = 2'b00;

      // T6: reset during EXEC, then during RESP; pointer must return to favour req0
      sel = 1'b0;
      set_req(0, 4'b0010, 32'd1, 32'd2);
      @(posedge clk);
      #1 v = 2'b00;
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_reset("rst_exec");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_last = 1'b1;
      set_req(0, 4'b0010, 32'd3, 32'd4);
      set_req(1, 4'b0010, 32'd5, 32'd6);
      txn(0);
      v = 2'b00;
      set_req(0, 4'b0011, 32'd7, 32'd8);
      @(posedge clk);
      #1 v = 2'b00;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_rsp_valid", 64'(o_rsp_valid), 64'd1);
      rst_n = 1'b0;
      #1 chk_reset("rst_resp");
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_last = 1'b1;
      set_req(0, 4'b0110, 32'd9, 32'd1);
      set_req(1, 4'b0110, 32'd8, 32'd2);
      txn(0);
      v = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
